// File: rtl/proc_defs_pkg.sv
// Shared pipeline definitions: opcodes, condition codes, flag indices, FSM encodings.
// Used by the decoder and the execute stage. EXECUTE_MUL_EN (in execute_unit) selects
// the iterative multiplier; nothing here depends on it.
package proc_defs;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 4;
   localparam int unsigned SUM_W  = DATA_W + 1;
   localparam int unsigned CNT_W  = 5;

   // Data-processing opcodes
   localparam logic [3:0] OP_AND = 4'h0;
   localparam logic [3:0] OP_EOR = 4'h1;
   localparam logic [3:0] OP_SUB = 4'h2;
   localparam logic [3:0] OP_RSB = 4'h3;
   localparam logic [3:0] OP_ADD = 4'h4;
   localparam logic [3:0] OP_ADC = 4'h5;
   localparam logic [3:0] OP_SBC = 4'h6;
   localparam logic [3:0] OP_RSC = 4'h7;
   localparam logic [3:0] OP_TST = 4'h8;
   localparam logic [3:0] OP_TEQ = 4'h9;
   localparam logic [3:0] OP_CMP = 4'hA;
   localparam logic [3:0] OP_CMN = 4'hB;
   localparam logic [3:0] OP_ORR = 4'hC;
   localparam logic [3:0] OP_MOV = 4'hD;
   localparam logic [3:0] OP_BIC = 4'hE;
   localparam logic [3:0] OP_MVN = 4'hF;

   // Condition codes
   localparam logic [3:0] CC_EQ = 4'h0;
   localparam logic [3:0] CC_NE = 4'h1;
   localparam logic [3:0] CC_CS = 4'h2;
   localparam logic [3:0] CC_CC = 4'h3;
   localparam logic [3:0] CC_MI = 4'h4;
   localparam logic [3:0] CC_PL = 4'h5;
   localparam logic [3:0] CC_VS = 4'h6;
   localparam logic [3:0] CC_VC = 4'h7;
   localparam logic [3:0] CC_HI = 4'h8;
   localparam logic [3:0] CC_LS = 4'h9;
   localparam logic [3:0] CC_GE = 4'hA;
   localparam logic [3:0] CC_LT = 4'hB;
   localparam logic [3:0] CC_GT = 4'hC;
   localparam logic [3:0] CC_LE = 4'hD;
   localparam logic [3:0] CC_AL = 4'hE;
   localparam logic [3:0] CC_NV = 4'hF;

   // Bit positions inside the {N,Z,C,V} flag vector
   localparam int unsigned FLAG_N = 3;
   localparam int unsigned FLAG_Z = 2;
   localparam int unsigned FLAG_C = 1;
   localparam int unsigned FLAG_V = 0;

   // Execute FSM encodings
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_MUL  = 1'b1;

   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } nzcv_t;

   // Condition-field evaluation against the current flags
   function automatic logic cond_pass(input logic [3:0] cc, input nzcv_t f);
      logic p;
      case (cc)
         CC_EQ:   p = f.z;
         CC_NE:   p = !f.z;
         CC_CS:   p = f.c;
         CC_CC:   p = !f.c;
         CC_MI:   p = f.n;
         CC_PL:   p = !f.n;
         CC_VS:   p = f.v;
         CC_VC:   p = !f.v;
         CC_HI:   p = f.c && !f.z;
         CC_LS:   p = !f.c || f.z;
         CC_GE:   p = (f.n == f.v);
         CC_LT:   p = (f.n != f.v);
         CC_GT:   p = !f.z && (f.n == f.v);
         CC_LE:   p = f.z || (f.n != f.v);
         CC_AL:   p = 1'b1;
         default: p = 1'b0;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/execute_unit_if.sv
// Decoder-to-execute bus: decoded operands/controls in, write port, flags and stall out.
// Signal set is the same with or without EXECUTE_MUL_EN.
interface execute_unit_if;
   import proc_defs::*;

   logic [DATA_W-1:0] operand0;
   logic [DATA_W-1:0] operand1;
   logic [3:0]        operation;
   logic [3:0]        cond;
   logic [ADDR_W-1:0] dest_addr;
   logic              update_flags;
   logic              use_flags;
   logic              shifter_carry;
   logic              NOP;
   logic              mul_req;

   logic              stall;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic [3:0]        flags;
   logic              cond_fail;

   // Upstream (decoder) side
   modport master (
      output operand0, operand1, operation, cond, dest_addr,
             update_flags, use_flags, shifter_carry, NOP, mul_req,
      input  stall, wr_en, wr_addr, wr_data, flags, cond_fail
   );

   // Execute-stage side
   modport slave (
      input  operand0, operand1, operation, cond, dest_addr,
             update_flags, use_flags, shifter_carry, NOP, mul_req,
      output stall, wr_en, wr_addr, wr_data, flags, cond_fail
   );

endinterface

// File: rtl/execute_unit_mul_iter.sv
// Iterative 32x32 multiplier, one shift-add per cycle, low 32 bits of the product.
// Instantiated by execute_unit only when EXECUTE_MUL_EN is defined.
// done/product are combinational so the last partial product lands on the finishing edge.
module mul_iter
   import proc_defs::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] product
);

   logic [DATA_W-1:0] a_q;
   logic [DATA_W-1:0] b_q;
   logic [DATA_W-1:0] acc;
   logic [CNT_W-1:0]  count;
   logic [DATA_W-1:0] partial_c;

   // Partial product for the bit selected by count, and the running sum including it
   always_comb begin
      partial_c = b_q[count] ? (a_q << count) : '0;
      product   = acc + partial_c;
      done      = busy && (count == CNT_W'(DATA_W - 1));
   end

   // Operand latch, accumulator and bit counter
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_q   <= '0;
         b_q   <= '0;
         acc   <= '0;
         count <= '0;
         busy  <= 1'b0;
      end else if (start) begin
         a_q   <= a;
         b_q   <= b;
         acc   <= '0;
         count <= '0;
         busy  <= 1'b1;
      end else if (busy) begin
         acc   <= product;
         count <= count + CNT_W'(1);
         if (done) begin
            busy <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/execute_unit.sv
// Execute stage: condition check, data-processing ALU, registered write port and NZCV.
// Define EXECUTE_MUL_EN to build in the iterative multiplier and its IDLE/MUL FSM;
// without it mul_req is ignored and stall is tied low.
module execute_unit
   import proc_defs::*;
(
   input logic           clk,
   input logic           rst_n,
   execute_unit_if.slave bus
);

   logic [DATA_W-1:0] alu_x;
   logic [DATA_W-1:0] alu_y;
   logic [SUM_W-1:0]  alu_sum;
   logic [DATA_W-1:0] logic_res;
   logic [DATA_W-1:0] alu_res;
   logic              alu_cin;
   logic              alu_arith;
   logic              alu_test;
   logic [3:0]        alu_flags;
   logic              pass_c;

   logic              wr_en_q;
   logic [ADDR_W-1:0] wr_addr_q;
   logic [DATA_W-1:0] wr_data_q;
   logic [3:0]        flags_q;
   logic              cond_fail_q;

   logic              nxt_wr_en;
   logic [ADDR_W-1:0] nxt_wr_addr;
   logic [DATA_W-1:0] nxt_wr_data;
   logic [3:0]        nxt_flags;
   logic              nxt_cond_fail;

`ifdef EXECUTE_MUL_EN
   logic [0:0]        state;
   logic [0:0]        nxt_state;
   logic              mul_start;
   logic              mul_done;
   logic [DATA_W-1:0] mul_product;
   logic [ADDR_W-1:0] mul_rd;
   logic              mul_s;
   logic              unused_mul_busy;

   mul_iter u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (mul_start),
      .a       (bus.operand0),
      .b       (bus.operand1),
      .busy    (unused_mul_busy),
      .done    (mul_done),
      .product (mul_product)
   );

   assign bus.stall = (state == ST_MUL);
`else
   logic unused_mul_req;

   assign unused_mul_req = bus.mul_req;
   assign bus.stall      = 1'b0;
`endif

   assign bus.wr_en     = wr_en_q;
   assign bus.wr_addr   = wr_addr_q;
   assign bus.wr_data   = wr_data_q;
   assign bus.flags     = flags_q;
   assign bus.cond_fail = cond_fail_q;

   assign pass_c = cond_pass(bus.cond, nzcv_t'(flags_q));

   // ALU: operand steering for add/subtract forms, logical results, and new NZCV
   always_comb begin
      alu_x     = bus.operand0;
      alu_y     = bus.operand1;
      alu_cin   = 1'b0;
      alu_arith = 1'b1;
      case (bus.operation)
         OP_SUB, OP_CMP: begin
            alu_y   = ~bus.operand1;
            alu_cin = 1'b1;
         end
         OP_RSB: begin
            alu_x   = bus.operand1;
            alu_y   = ~bus.operand0;
            alu_cin = 1'b1;
         end
         OP_ADD, OP_CMN: alu_cin = 1'b0;
         OP_ADC: alu_cin = bus.use_flags ? flags_q[FLAG_C] : 1'b0;
         OP_SBC: begin
            alu_y   = ~bus.operand1;
            alu_cin = bus.use_flags ? flags_q[FLAG_C] : 1'b1;
         end
         OP_RSC: begin
            alu_x   = bus.operand1;
            alu_y   = ~bus.operand0;
            alu_cin = bus.use_flags ? flags_q[FLAG_C] : 1'b1;
         end
         default: alu_arith = 1'b0;
      endcase

      alu_sum = {1'b0, alu_x} + {1'b0, alu_y} + SUM_W'(alu_cin);

      case (bus.operation)
         OP_AND, OP_TST: logic_res = bus.operand0 & bus.operand1;
         OP_EOR, OP_TEQ: logic_res = bus.operand0 ^ bus.operand1;
         OP_ORR:         logic_res = bus.operand0 | bus.operand1;
         OP_MOV:         logic_res = bus.operand1;
         OP_BIC:         logic_res = bus.operand0 & ~bus.operand1;
         OP_MVN:         logic_res = ~bus.operand1;
         default:        logic_res = '0;
      endcase

      alu_res  = alu_arith ? alu_sum[DATA_W-1:0] : logic_res;
      alu_test = bus.operation inside {OP_TST, OP_TEQ, OP_CMP, OP_CMN};

      alu_flags         = flags_q;
      alu_flags[FLAG_N] = alu_res[DATA_W-1];
      alu_flags[FLAG_Z] = (alu_res == '0);
      alu_flags[FLAG_C] = alu_arith ? alu_sum[DATA_W] : bus.shifter_carry;
      if (alu_arith) begin
         alu_flags[FLAG_V] = (alu_x[DATA_W-1] == alu_y[DATA_W-1]) &&
                             (alu_sum[DATA_W-1] != alu_x[DATA_W-1]);
      end
   end

   // Next-state and next-output logic: accept, squash, execute, or finish a multiply
   always_comb begin
      nxt_wr_en     = 1'b0;
      nxt_cond_fail = 1'b0;
      nxt_wr_addr   = wr_addr_q;
      nxt_wr_data   = wr_data_q;
      nxt_flags     = flags_q;
`ifdef EXECUTE_MUL_EN
      nxt_state     = state;
      mul_start     = 1'b0;
      if (state == ST_MUL) begin
         if (mul_done) begin
            nxt_state   = ST_IDLE;
            nxt_wr_en   = 1'b1;
            nxt_wr_addr = mul_rd;
            nxt_wr_data = mul_product;
            if (mul_s) begin
               nxt_flags[FLAG_N] = mul_product[DATA_W-1];
               nxt_flags[FLAG_Z] = (mul_product == '0);
            end
         end
      end else
`endif
      if (!bus.NOP) begin
         if (!pass_c) begin
            nxt_cond_fail = 1'b1;
         end
`ifdef EXECUTE_MUL_EN
         else if (bus.mul_req) begin
            mul_start = 1'b1;
            nxt_state = ST_MUL;
         end
`endif
         else begin
            if (!alu_test) begin
               nxt_wr_en   = 1'b1;
               nxt_wr_addr = bus.dest_addr;
               nxt_wr_data = alu_res;
            end
            if (alu_test || bus.update_flags) begin
               nxt_flags = alu_flags;
            end
         end
      end
   end

`ifdef EXECUTE_MUL_EN
   // FSM state register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= nxt_state;
      end
   end

   // Destination and S bit of the multiply in flight
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mul_rd <= '0;
         mul_s  <= 1'b0;
      end else if (mul_start) begin
         mul_rd <= bus.dest_addr;
         mul_s  <= bus.update_flags;
      end
   end
`endif

   // Registered write port, flags and squash pulse
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         flags_q     <= '0;
         cond_fail_q <= 1'b0;
      end else begin
         wr_en_q     <= nxt_wr_en;
         wr_addr_q   <= nxt_wr_addr;
         wr_data_q   <= nxt_wr_data;
         flags_q     <= nxt_flags;
         cond_fail_q <= nxt_cond_fail;
      end
   end

endmodule

// File: tb/tb_execute_unit.sv
// Self-checking bench for execute_unit: directed cases plus randomized instructions
// checked against an arithmetic reference model. Multiply cases need EXECUTE_MUL_EN.
module tb_execute_unit;

   logic clk;
   logic rst_n;

   execute_unit_if bus();

   execute_unit dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int unsigned n_vec;
   int unsigned n_err;

   logic [3:0]  m_flags;
   logic [3:0]  m_addr;
   logic [31:0] m_data;

   localparam longint SMAX = 64'sd2147483647;
   localparam longint SMIN = -64'sd2147483648;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic cond_ok(input logic [3:0] cc, input logic [3:0] f);
      logic n, z, c, v;
      {n, z, c, v} = f;
      case (cc)
         4'd0:    return z;
         4'd1:    return !z;
         4'd2:    return c;
         4'd3:    return !c;
         4'd4:    return n;
         4'd5:    return !n;
         4'd6:    return v;
         4'd7:    return !v;
         4'd8:    return c && !z;
         4'd9:    return !c || z;
         4'd10:   return n == v;
         4'd11:   return n != v;
         4'd12:   return !z && (n == v);
         4'd13:   return z || (n != v);
         4'd14:   return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // Reference: integer add/subtract with borrow, overflow from true signed range
   task automatic ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic uf, input logic sc, input logic [3:0] fl,
                          output logic [31:0] res, output logic [3:0] nf, output logic wr);
      logic [31:0] m, t;
      logic        k, is_sub, arith, cout, vout;
      logic [63:0] ua;
      longint      sa;
      m = a; t = b; k = 1'b0; is_sub = 1'b0; arith = 1'b1;
      cout = 1'b0; vout = 1'b0; res = 32'd0;
      wr = !(op inside {4'h8, 4'h9, 4'hA, 4'hB});
      case (op)
         4'h4, 4'hB: ;
         4'h5: k = uf ? fl[1] : 1'b0;
         4'h2, 4'hA: is_sub = 1'b1;
         4'h3: begin is_sub = 1'b1; m = b; t = a; end
         4'h6: begin is_sub = 1'b1; k = uf ? !fl[1] : 1'b0; end
         4'h7: begin is_sub = 1'b1; m = b; t = a; k = uf ? !fl[1] : 1'b0; end
         default: arith = 1'b0;
      endcase
      if (arith) begin
         if (is_sub) begin
            ua   = {32'd0, m} - {32'd0, t} - 64'(k);
            sa   = longint'($signed(m)) - longint'($signed(t)) - longint'(k);
            cout = ({32'd0, m} >= ({32'd0, t} + 64'(k)));
         end else begin
            ua   = {32'd0, m} + {32'd0, t} + 64'(k);
            sa   = longint'($signed(m)) + longint'($signed(t)) + longint'(k);
            cout = ua[32];
         end
         res  = ua[31:0];
         vout = (sa > SMAX) || (sa < SMIN);
      end else begin
         case (op)
            4'h0, 4'h8: res = a & b;
            4'h1, 4'h9: res = a ^ b;
            4'hC:       res = a | b;
            4'hD:       res = b;
            4'hE:       res = a & ~b;
            default:    res = ~b;
         endcase
         cout = sc;
         vout = fl[0];
      end
      nf = fl;
      if (!wr || s) nf = {res[31], (res == 32'd0), cout, vout};
   endtask

   task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] cc, input logic [3:0] rd, input logic s,
                        input logic uf, input logic sc, input logic nop, input logic mul);
      bus.operation     = op;
      bus.operand0      = a;
      bus.operand1      = b;
      bus.cond          = cc;
      bus.dest_addr     = rd;
      bus.update_flags  = s;
      bus.use_flags     = uf;
      bus.shifter_carry = sc;
      bus.NOP           = nop;
      bus.mul_req       = mul;
   endtask

   // One accepted single-cycle instruction (or bubble/squash), checked after the edge
   task automatic step(input string tag);
      logic        exp_wr, exp_cf, w;
      logic [31:0] r;
      logic [3:0]  nf;
      exp_wr = 1'b0;
      exp_cf = 1'b0;
      if (!bus.NOP) begin
         if (!cond_ok(bus.cond, m_flags)) begin
            exp_cf = 1'b1;
         end else begin
            ref_alu(bus.operation, bus.operand0, bus.operand1, bus.update_flags,
                    bus.use_flags, bus.shifter_carry, m_flags, r, nf, w);
            m_flags = nf;
            exp_wr  = w;
            if (w) begin
               m_addr = bus.dest_addr;
               m_data = r;
            end
         end
      end
      @(posedge clk); #1;
      chk({tag, ".wr_en"},     32'(bus.wr_en),     32'(exp_wr));
      chk({tag, ".cond_fail"}, 32'(bus.cond_fail), 32'(exp_cf));
      chk({tag, ".flags"},     32'(bus.flags),     32'(m_flags));
      chk({tag, ".stall"},     32'(bus.stall),     32'd0);
      if (exp_wr) begin
         chk({tag, ".wr_addr"}, 32'(bus.wr_addr), 32'(m_addr));
         chk({tag, ".wr_data"}, bus.wr_data,      m_data);
      end
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'h7FFF_FFFF;
         default: return 32'($urandom);
      endcase
   endfunction

`ifdef EXECUTE_MUL_EN
   // MUL accepted at E0, held ADD presented during the stall, writeback after E0+32
   task automatic mul_run(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] rd, input logic s);
      logic [63:0] full;
      logic [31:0] p;
      full = {32'd0, a} * {32'd0, b};
      p    = full[31:0];
      drive(4'h4, a, b, 4'hE, rd, s, 1'b0, 1'b0, 1'b0, 1'b1);
      @(posedge clk); #1;
      chk({tag, ".stall_e0"}, 32'(bus.stall), 32'd1);
      chk({tag, ".wr_en_e0"}, 32'(bus.wr_en), 32'd0);
      drive(4'h4, 32'h1111_1111, 32'h2222_2222, 4'hE, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int k = 1; k <= 31; k++) begin
         @(posedge clk); #1;
         chk({tag, ".stall_run"}, 32'(bus.stall), 32'd1);
         chk({tag, ".wr_en_run"}, 32'(bus.wr_en), 32'd0);
      end
      @(posedge clk); #1;
      if (s) begin
         m_flags[3] = p[31];
         m_flags[2] = (p == 32'd0);
      end
      m_addr = rd;
      m_data = p;
      chk({tag, ".stall_end"}, 32'(bus.stall),     32'd0);
      chk({tag, ".wr_en"},     32'(bus.wr_en),     32'd1);
      chk({tag, ".wr_addr"},   32'(bus.wr_addr),   32'(rd));
      chk({tag, ".wr_data"},   bus.wr_data,        p);
      chk({tag, ".flags"},     32'(bus.flags),     32'(m_flags));
      chk({tag, ".cond_fail"}, 32'(bus.cond_fail), 32'd0);
   endtask
`endif

   initial begin
      n_vec   = 0;
      n_err   = 0;
      m_flags = 4'b0000;
      m_addr  = 4'd0;
      m_data  = 32'd0;
      rst_n   = 1'b0;
      drive(4'h0, 32'd0, 32'd0, 4'hE, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst.wr_en",     32'(bus.wr_en),     32'd0);
      chk("rst.wr_addr",   32'(bus.wr_addr),   32'd0);
      chk("rst.wr_data",   bus.wr_data,        32'd0);
      chk("rst.flags",     32'(bus.flags),     32'd0);
      chk("rst.cond_fail", 32'(bus.cond_fail), 32'd0);
      chk("rst.stall",     32'(bus.stall),     32'd0);
      rst_n = 1'b1;

      // ADD wrapping to zero
      drive(4'h4, 32'hFFFF_FFFF, 32'd1, 4'hE, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step("add_wrap");
      chk("add_wrap.nzcv", 32'(bus.flags), 32'b0110);

      // SUB signed overflow, then EQ MOV squashed
      drive(4'h2, 32'h8000_0000, 32'd1, 4'hE, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step("sub_ovf");
      chk("sub_ovf.data", bus.wr_data, 32'h7FFF_FFFF);
      chk("sub_ovf.nzcv", 32'(bus.flags), 32'b0011);
      drive(4'hD, 32'd0, 32'h1234_5678, 4'h0, 4'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      step("mov_eq_fail");
      chk("mov_eq_fail.cf", 32'(bus.cond_fail), 32'd1);

      // CMP sets flags without S, ADC consumes C
      drive(4'hA, 32'd5, 32'd5, 4'hE, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step("cmp_eq");
      chk("cmp_eq.nzcv", 32'(bus.flags), 32'b0110);
      drive(4'h5, 32'd1, 32'd1, 4'hE, 4'd6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      step("adc_c");
      chk("adc_c.data", bus.wr_data, 32'd3);

      // Bubble stream, then never-condition
      for (int i = 0; i < 4; i++) begin
         drive(4'($urandom), pick(), pick(), 4'hE, 4'($urandom), 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
         step("nop");
      end
      drive(4'h4, 32'd7, 32'd8, 4'hF, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step("never");
      drive(4'h4, 32'd7, 32'd8, 4'hF, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      step("never_mul");

`ifdef EXECUTE_MUL_EN
      // Set C and V so the multiply can show it leaves them alone
      drive(4'h2, 32'h8000_0000, 32'd1, 4'hE, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step("pre_mul");
      mul_run("mul_dir", 32'h0001_0000, 32'h0001_0001, 4'd5, 1'b1);
      chk("mul_dir.nzcv", 32'(bus.flags), 32'b0011);
      step("add_after_mul");
      for (int i = 0; i < 2; i++) begin
         mul_run("mul_rnd", 32'($urandom), 32'($urandom), 4'($urandom), 1'($urandom));
         step("held_after_mul");
      end

      // Reset in the middle of a multiply discards it
      drive(4'h4, 32'h0000_0003, 32'h0000_0005, 4'hE, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      @(posedge clk); #1;
      chk("mul_rst.stall_e0", 32'(bus.stall), 32'd1);
      drive(4'h4, 32'd1, 32'd1, 4'hE, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int k = 1; k < 10; k++) begin
         @(posedge clk); #1;
         chk("mul_rst.wr_en_run", 32'(bus.wr_en), 32'd0);
      end
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n    = 1'b1;
      bus.NOP  = 1'b1;
      m_flags  = 4'b0000;
      chk("mul_rst.stall", 32'(bus.stall), 32'd0);
      chk("mul_rst.flags", 32'(bus.flags), 32'd0);
      chk("mul_rst.wr_en", 32'(bus.wr_en), 32'd0);
      for (int k = 0; k < 30; k++) step("mul_rst.quiet");
`else
      // Without the multiplier, mul_req runs as its opcode with no stall
      drive(4'h4, 32'd20, 32'd22, 4'hE, 4'd11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      step("mul_ignored");
      chk("mul_ignored.data", bus.wr_data, 32'd42);
`endif

      // Randomized instruction stream
      for (int i = 0; i < 300; i++) begin
         logic [3:0] cc;
         logic       mul;
         cc = ($urandom_range(0, 2) == 0) ? 4'hE : 4'($urandom);
`ifdef EXECUTE_MUL_EN
         mul = 1'b0;
`else
         mul = 1'($urandom);
`endif
         drive(4'($urandom), pick(), pick(), cc, 4'($urandom), 1'($urandom), 1'($urandom),
               1'($urandom), ($urandom_range(0, 7) == 0), mul);
         step("rnd");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
